i2c_init_seq: RTL and testbench

//  Table-driven register-write sequencer for the i2c byte master. On start, walks an external

---
 rtl/i2c_init_seq_pkg.sv | 27 ++
 rtl/i2c_init_seq_if.sv | 30 +++
 rtl/i2c_init_seq_timer.sv | 44 ++++
 rtl/i2c_init_seq.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_init_seq_pkg.sv
// Shared types for the init sequencer: table-entry tags, entry layout, FSM states.
// Imported by the sequencer top and its timer.
package i2c_init_seq_pkg;

  localparam logic [7:0] TAG_END   = 8'hFF;
  localparam logic [7:0] TAG_DELAY = 8'hFE;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_REQREG  = 4'd3,
    S_WAITREG = 4'd4,
    S_REQDAT  = 4'd5,
    S_WAITDAT = 4'd6,
    S_DELAY   = 4'd7,
    S_GAP     = 4'd8,
    S_FINISH  = 4'd9
  } state_t;

endpackage

// File: rtl/i2c_init_seq_if.sv
// Byte-request handshake between the init sequencer and the i2c byte master.
// master: sequencer side (drives req/addr/wdata/last); slave: byte-master side (drives ack/err).
interface i2c_init_seq_if;

  logic [7:0] i2caddr;
  logic [7:0] i2cwdata;
  logic       i2creq;
  logic       i2clast;
  logic       i2cack;
  logic       i2cerr;

  modport master (
    output i2caddr,
    output i2cwdata,
    output i2creq,
    output i2clast,
    input  i2cack,
    input  i2cerr
  );

  modport slave (
    input  i2caddr,
    input  i2cwdata,
    input  i2creq,
    input  i2clast,
    output i2cack,
    output i2cerr
  );

endinterface

// File: rtl/i2c_init_seq_timer.sv
// Loadable down-counter with unit prescaler; times DELAY entries and retry gaps.
// Ports: clk, rst, load/scale/units (arm), run (count enable), last (final cycle flag).
module i2c_init_seq_timer #(
  parameter int UNIT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        scale,
  input  logic [31:0] units,
  input  logic        run,
  output logic        last
);

  localparam int PW = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam logic [PW-1:0] PTOP = PW'(UNIT - 1);

  logic [PW-1:0] pre;
  logic [31:0]   cnt;
  logic          sc;

  // A zero-unit load still lasts one cycle: both counters start at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
      sc  <= 1'b0;
    end else if (load) begin
      sc  <= scale;
      cnt <= (units == 32'd0) ? 32'd0 : units - 32'd1;
      pre <= (scale && units != 32'd0) ? PTOP : '0;
    end else if (run) begin
      if (pre != '0) begin
        pre <= pre - 1'b1;
      end else if (cnt != 32'd0) begin
        cnt <= cnt - 32'd1;
        pre <= sc ? PTOP : '0;
      end
    end
  end

  assign last = run && (pre == '0) && (cnt == 32'd0);

endmodule

// File: rtl/i2c_init_seq.sv
// Table-driven register-write sequencer: walks {dev,reg,data} entries into i2c writes.
// Ports: start/busy/done/err/erridx status, taddr/tdata table, bus = byte-master handshake.
module i2c_init_seq
  import i2c_init_seq_pkg::*;
#(
  parameter int TABW      = 5,
  parameter int DELAYUNIT = 1000,
  parameter int MAXRETRY  = 3,
  parameter int RETRYGAP  = 4000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [TABW-1:0] erridx,
  output logic [TABW-1:0] taddr,
  input  logic [23:0]     tdata,
  i2c_init_seq_if.master  bus
);

  localparam int RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;
  localparam logic [TABW-1:0] TLAST = '1;

  state_t        state;
  state_t        nxt;
  entry_t        ent;
  entry_t        tent;
  logic [7:0]    src_dev;
  logic [7:0]    src_rg;
  logic [RW-1:0] retry;

  logic          go;
  logic          adv;
  logic          nak;
  logic          retry_ok;
  logic          fail;
  logic          ld_reg;
  logic          ld_dat;
  logic          tmr_ld;
  logic          tmr_scale;
  logic          tmr_run;
  logic          tmr_last;
  logic [31:0]   tmr_units;

  assign tent = entry_t'(tdata);

  // Table word is only valid in DECODE; later (retries, data byte) use the latched copy.
  assign src_dev = (state == S_DECODE) ? tent.dev : ent.dev;
  assign src_rg  = (state == S_DECODE) ? tent.rg  : ent.rg;

  assign retry_ok = int'(retry) < MAXRETRY;
  assign busy     = (state != S_IDLE) && (state != S_FINISH);
  assign done     = (state == S_FINISH);
  assign tmr_run  = (state == S_DELAY) || (state == S_GAP);

  assign bus.i2creq = (state == S_REQREG) || (state == S_REQDAT);

  i2c_init_seq_timer #(
    .UNIT (DELAYUNIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_ld),
    .scale (tmr_scale),
    .units (tmr_units),
    .run   (tmr_run),
    .last  (tmr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt       = state;
    go        = 1'b0;
    adv       = 1'b0;
    nak       = 1'b0;
    fail      = 1'b0;
    ld_reg    = 1'b0;
    ld_dat    = 1'b0;
    tmr_ld    = 1'b0;
    tmr_scale = 1'b0;
    tmr_units = 32'd0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nxt = S_FETCH;
          go  = 1'b1;
        end
      end
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        if (tent.dev == TAG_END) begin
          nxt = S_FINISH;
        end else if (tent.dev == TAG_DELAY) begin
          nxt       = S_DELAY;
          tmr_ld    = 1'b1;
          tmr_scale = 1'b1;
          tmr_units = {16'd0, tdata[15:0]};
        end else begin
          nxt    = S_REQREG;
          ld_reg = 1'b1;
        end
      end
      S_REQREG: nxt = S_WAITREG;
      S_WAITREG: begin
        if (bus.i2cack) begin
          if (bus.i2cerr) begin
            nak = 1'b1;
          end else begin
            nxt    = S_REQDAT;
            ld_dat = 1'b1;
          end
        end
      end
      S_REQDAT: nxt = S_WAITDAT;
      S_WAITDAT: begin
        if (bus.i2cack) begin
          nak = bus.i2cerr;
          adv = !bus.i2cerr;
        end
      end
      S_DELAY: adv = tmr_last;
      S_GAP: begin
        if (tmr_last) begin
          nxt    = S_REQREG;
          ld_reg = 1'b1;
        end
      end
      S_FINISH: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase

    // Table end is a hard stop: the index never wraps back to 0.
    if (adv) begin
      nxt = (taddr == TLAST) ? S_FINISH : S_FETCH;
    end

    if (nak) begin
      if (retry_ok) begin
        nxt       = S_GAP;
        tmr_ld    = 1'b1;
        tmr_units = 32'(RETRYGAP);
      end else begin
        nxt  = S_FINISH;
        fail = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taddr        <= '0;
      retry        <= '0;
      err          <= 1'b0;
      erridx       <= '0;
      ent          <= '0;
      bus.i2caddr  <= 8'd0;
      bus.i2cwdata <= 8'd0;
      bus.i2clast  <= 1'b0;
    end else begin
      if (go) begin
        taddr <= '0;
        retry <= '0;
        err   <= 1'b0;
      end
      if (adv) begin
        retry <= '0;
        if (taddr != TLAST) begin
          taddr <= taddr + 1'b1;
        end
      end
      if (nak && retry_ok) begin
        retry <= retry + 1'b1;
      end
      if (fail) begin
        err    <= 1'b1;
        erridx <= taddr;
      end
      if (state == S_DECODE) begin
        ent <= tent;
      end
      if (ld_reg) begin
        bus.i2caddr  <= {src_dev[7:1], 1'b0};
        bus.i2cwdata <= src_rg;
        bus.i2clast  <= 1'b0;
      end
      if (ld_dat) begin
        bus.i2cwdata <= ent.dat;
        bus.i2clast  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: handshake-level byte master/slave model plus a table-walk
// reference that predicts every byte request, its cycle gap, and the final status.
module tb_i2c_init_seq;

  localparam int TABW = 3;
  localparam int N    = 8;
  localparam int DU   = 10;
  localparam int MR   = 2;
  localparam int RG   = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            err;
  logic [TABW-1:0] erridx;
  logic [TABW-1:0] taddr;
  logic [23:0]     tdata;

  i2c_init_seq_if bif ();

  i2c_init_seq #(
    .TABW      (TABW),
    .DELAYUNIT (DU),
    .MAXRETRY  (MR),
    .RETRYGAP  (RG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .erridx (erridx),
    .taddr  (taddr),
    .tdata  (tdata),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  logic [23:0] tab [N];
  always @(posedge clk) tdata <= tab[taddr];

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit         dn;
    logic [7:0] a;
    logic [7:0] d;
    bit         l;
    int         gap;
  } ev_t;

  ev_t expq[$];
  bit  exp_err;
  int  exp_idx;
  int  exp_ta;
  int  cfg_nr [256];
  int  cfg_nd [256];
  int  slv_nr [256];
  int  slv_nd [256];
  int  cyc = 0;
  int  ref_cyc = 0;
  int  done_cnt = 0;
  bit  mon_en = 1'b0;

  task automatic push(bit dn, logic [7:0] a, logic [7:0] d, bit l, int g);
    ev_t e;
    e.dn = dn; e.a = a; e.d = d; e.l = l; e.gap = g;
    expq.push_back(e);
  endtask

  // Walk the table as the sequencer is described: each entry costs a fetch and a
  // decode cycle, writes are reg then data bytes, NAKs back off RG cycles.
  task automatic model();
    int  acc;
    int  r;
    int  d;
    int  tries;
    int  units;
    int  g;
    bit  fin;
    bit  nakd;
    logic [7:0] dev;
    logic [7:0] ka;
    expq.delete();
    exp_err = 0;
    exp_idx = 0;
    acc = 0;
    fin = 0;
    for (int i = 0; i < N && !fin; i++) begin
      dev = tab[i][23:16];
      acc += 2;
      exp_ta = i;
      if (dev == 8'hFF) begin
        push(1, 0, 0, 0, acc + 1);
        fin = 1;
      end else if (dev == 8'hFE) begin
        units = int'(tab[i][15:0]) * DU;
        if (units == 0) units = 1;
        acc += units;
        if (i == N - 1) push(1, 0, 0, 0, acc + 1);
      end else begin
        ka = dev & 8'hFE;
        r = cfg_nr[ka];
        d = cfg_nd[ka];
        tries = 0;
        g = acc + 1;
        while (1) begin
          push(0, ka, tab[i][15:8], 0, g);
          nakd = 0;
          if (r > 0) begin
            r--;
            nakd = 1;
          end else begin
            push(0, ka, tab[i][7:0], 1, 1);
            if (d > 0) begin
              d--;
              nakd = 1;
            end
          end
          if (!nakd) begin
            acc = 0;
            if (i == N - 1) push(1, 0, 0, 0, 1);
            break;
          end
          if (tries < MR) begin
            tries++;
            g = RG + 1;
          end else begin
            exp_err = 1;
            exp_idx = i;
            push(1, 0, 0, 0, 1);
            fin = 1;
            break;
          end
        end
      end
    end
  endtask

  // Byte master + slave at handshake level: random ack latency, NAKs per device budget,
  // garbage on i2cerr whenever ack is low.
  initial begin
    logic [7:0] a;
    logic [7:0] w;
    logic       l;
    bit         nk;
    bif.i2cack = 1'b0;
    bif.i2cerr = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.i2creq && !rst) begin
        a = bif.i2caddr;
        w = bif.i2cwdata;
        l = bif.i2clast;
        if (l) begin
          nk = slv_nd[a] > 0;
          if (nk) slv_nd[a]--;
        end else begin
          nk = slv_nr[a] > 0;
          if (nk) slv_nr[a]--;
        end
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check("hold_addr", bif.i2caddr, a);
        check("hold_wdata", bif.i2cwdata, w);
        check("hold_last", bif.i2clast, l);
        bif.i2cack = 1'b1;
        bif.i2cerr = nk;
        @(posedge clk);
        #1;
        bif.i2cack = 1'b0;
        bif.i2cerr = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (start && !busy) ref_cyc = cyc;
        if (bif.i2cack) ref_cyc = cyc;
        if (bif.i2creq) begin
          check("req_busy", busy, 1);
          if (expq.size() == 0) begin
            check("extra_req", 1, 0);
          end else begin
            e = expq.pop_front();
            check("req_kind", e.dn, 0);
            check("req_addr", bif.i2caddr, e.a);
            check("req_wdata", bif.i2cwdata, e.d);
            check("req_last", bif.i2clast, e.l);
            check("req_gap", cyc - ref_cyc, e.gap);
          end
        end
        if (done) begin
          done_cnt++;
          check("done_busy", busy, 0);
          if (expq.size() == 0) begin
            check("extra_done", 1, 0);
          end else begin
            e = expq.pop_front();
            check("done_kind", e.dn, 1);
            check("done_gap", cyc - ref_cyc, e.gap);
            check("done_err", err, exp_err);
            if (exp_err) check("done_erridx", erridx, exp_idx);
            check("done_taddr", taddr, exp_ta);
          end
        end
      end
    end
  end

  task automatic chk_reset(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_erridx"}, erridx, 0);
    check({tag, "_taddr"}, taddr, 0);
    check({tag, "_req"}, bif.i2creq, 0);
    check({tag, "_last"}, bif.i2clast, 0);
    check({tag, "_addr"}, bif.i2caddr, 0);
    check({tag, "_wdata"}, bif.i2cwdata, 0);
  endtask

  task automatic clr_cfg();
    for (int k = 0; k < 256; k++) begin
      cfg_nr[k] = 0;
      cfg_nd[k] = 0;
    end
  endtask

  task automatic kick();
    model();
    for (int k = 0; k < 256; k++) begin
      slv_nr[k] = cfg_nr[k];
      slv_nd[k] = cfg_nd[k];
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(int extra_at, int budget);
    int base;
    int t;
    base = done_cnt;
    kick();
    t = 0;
    while (done_cnt == base && t < budget) begin
      @(posedge clk);
      #1;
      t++;
      start = (t == extra_at && busy) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("timeout", done_cnt == base, 0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_left", expq.size(), 0);
    check("idle_busy", busy, 0);
    check("err_hold", err, exp_err);
  endtask

  task automatic fill_rand();
    int n;
    int k;
    logic [7:0] dev;
    clr_cfg();
    n = $urandom_range(1, N);
    for (int i = 0; i < N; i++) begin
      k = $urandom_range(0, 9);
      if (i >= n) begin
        tab[i] = (i == n) ? 24'hFF0000 : {8'(8'h60 + 2 * i), 16'($urandom)};
      end else if (k < 7) begin
        dev = 8'(8'h20 + 2 * i + $urandom_range(0, 1));
        tab[i] = {dev, 16'($urandom)};
        cfg_nr[dev & 8'hFE] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
        cfg_nd[dev & 8'hFE] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      end else if (k < 9) begin
        tab[i] = {8'hFE, 16'($urandom_range(0, 3))};
      end else begin
        tab[i] = 24'hFF0000;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) tab[i] = 24'hFF0000;
    clr_cfg();
    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    tab[0] = 24'h3410AB;
    tab[1] = 24'hFF0000;
    tab[2] = 24'h501122;
    run(0, 2000);

    tab[0] = 24'h340102;
    tab[1] = 24'hFE0003;
    tab[2] = 24'h370304;
    tab[3] = 24'h380506;
    tab[4] = 24'hFF0000;
    cfg_nr[8'h34] = 2;
    run(15, 4000);

    clr_cfg();
    tab[0] = 24'h40A1A2;
    tab[1] = 24'h42B1B2;
    tab[2] = 24'h44C1C2;
    tab[3] = 24'h46D1D2;
    tab[4] = 24'hFF0000;
    cfg_nd[8'h44] = 255;
    run(0, 4000);

    clr_cfg();
    for (int i = 0; i < N; i++) tab[i] = {8'(8'h50 + 2 * i), 8'(i), 8'(8'hC0 + i)};
    tab[5] = 24'hFE0000;
    run(7, 4000);

    clr_cfg();
    tab[0] = 24'h400102;
    tab[1] = 24'hFE0064;
    tab[2] = 24'h420304;
    tab[3] = 24'hFF0000;
    kick();
    repeat (300) @(posedge clk);
    #1;
    check("mid_delay_busy", busy, 1);
    #2 rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk_reset("mid");
    expq.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    tab[1] = 24'hFE0002;
    run(0, 4000);

    for (int r = 0; r < 14; r++) begin
      fill_rand();
      run($urandom_range(0, 12), 8000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
